int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 15 +
 rtl/int_timer.sv | 23 ++
 rtl/int_ctrl.sv | 103 ++++++++++
 tb/tb_int_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared CPU interrupt constants, FSM encodings and CP0 register indices
package int_ctrl_pkg;
  localparam int NSRC = 7;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_ACK} state_t;
  function automatic logic [2:0] lowest(input logic [NSRC-1:0] v);
    lowest = '0;
    for (int i = NSRC-1; i >= 0; i--) if (v[i]) lowest = 3'(i);
  endfunction
  function automatic logic [NSRC-1:0] onehot(input logic [2:0] i);
    onehot = NSRC'(1) << i;
  endfunction
endpackage

// File: rtl/int_timer.sv
// int_timer: 32-bit auto-reload down-timer; tick_o pulses once per load-value cycles
module int_timer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        we_i,
  input  logic [31:0] load_i,
  output logic        tick_o
);
  logic [31:0] load_q, cnt_q;
  logic        run_q;
  assign tick_o = run_q && cnt_q == 32'd1;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      load_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (we_i) begin
      load_q <= load_i;
      cnt_q  <= load_i;
      run_q  <= |load_i;
    end else if (tick_o) cnt_q <= load_q;
    else if (run_q) cnt_q <= cnt_q - 32'd1;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: synchronizes IRQ lines into a pending register and presents one request at a time to CP0.
// Define INT_TIMER_EN to replace source 6 with the int_timer auto-reload timer.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NSRC-1:0] IRQ_IN,
  input  logic            PIPELINE_READY,
  input  logic            S_INT,
  input  logic            MASK_WE,
  input  logic [NSRC-1:0] MASK_IN,
  input  logic            CLR_WE,
  input  logic [NSRC-1:0] CLR_IN,
`ifdef INT_TIMER_EN
  input  logic            TIMER_WE,
  input  logic [31:0]     TIMER_LOAD,
`endif
  output logic [NSRC-1:0] INT_OUT,
  output logic [NSRC-1:0] PENDING,
  output logic            BUSY
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
  logic [NSRC-1:0] prev_q, pend_q, pend_d, mask_q, lvl, cap_raw, cap, clr;
  state_t state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ack;
  assign lvl     = sync_q[SYNC_STAGES-1];
  assign cap_raw = EDGE_MODE != 0 ? lvl & ~prev_q : lvl;
`ifdef INT_TIMER_EN
  logic tick;
  int_timer u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .we_i  (TIMER_WE),
    .load_i(TIMER_LOAD),
    .tick_o(tick)
  );
  assign cap = {tick, cap_raw[NSRC-2:0]};
`else
  assign cap = cap_raw;
`endif
  // capture after clear so a coincident set always wins
  assign clr     = (CLR_WE ? CLR_IN : '0) | (ack ? onehot(sel_q) : '0);
  assign pend_d  = (pend_q & ~clr) | cap;
  assign PENDING = pend_q;
  assign BUSY    = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    INT_OUT = '0;
    ack     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|(pend_q & mask_q)) begin
          sel_d   = lowest(pend_q & mask_q);
          state_d = PRESENT;
        end
      end
      PRESENT:
        if (!mask_q[sel_q] || !pend_q[sel_q]) state_d = IDLE;
        else if (PIPELINE_READY) begin
          INT_OUT = onehot(sel_q);
          state_d = WAIT_ACK;
        end
      WAIT_ACK:
        if (S_INT) begin
          ack     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q == '1 ? cnt_q : cnt_q + CW'(1);
          if (cnt_q == CW'(ACK_TIMEOUT - 1)) state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], IRQ_IN};
      prev_q  <= lvl;
      pend_q  <= pend_d;
      mask_q  <= MASK_WE ? MASK_IN : mask_q;
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vectors for int_ctrl with hand-computed expectations
module tb_int_ctrl;
  logic       CLK = 1'b0, RESET = 1'b1, PIPELINE_READY = 1'b0, S_INT = 1'b0;
  logic       MASK_WE = 1'b0, CLR_WE = 1'b0;
  logic [6:0] IRQ_IN = '0, MASK_IN = '0, CLR_IN = '0;
  logic [6:0] INT_OUT, PENDING;
  logic       BUSY;
`ifdef INT_TIMER_EN
  logic        TIMER_WE = 1'b0;
  logic [31:0] TIMER_LOAD = '0;
`endif
  int nvec = 0, nerr = 0;
  int_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IRQ_IN        (IRQ_IN),
    .PIPELINE_READY(PIPELINE_READY),
    .S_INT         (S_INT),
    .MASK_WE       (MASK_WE),
    .MASK_IN       (MASK_IN),
    .CLR_WE        (CLR_WE),
    .CLR_IN        (CLR_IN),
`ifdef INT_TIMER_EN
    .TIMER_WE      (TIMER_WE),
    .TIMER_LOAD    (TIMER_LOAD),
`endif
    .INT_OUT       (INT_OUT),
    .PENDING       (PENDING),
    .BUSY          (BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  initial begin
    IRQ_IN = 7'h10;
    PIPELINE_READY = 1'b1;
    cyc(2);
    #1;
    chk("rst_pend", PENDING, 7'h00);
    chk("rst_busy", BUSY, 0);
    chk("rst_int", INT_OUT, 7'h00);
    PIPELINE_READY = 1'b0;
    cyc(1);
    RESET = 1'b0;
    cyc(2);
    chk("hold_early", PENDING, 7'h00);
    cyc(1);
    chk("hold_cap", PENDING, 7'h10);
    IRQ_IN = '0;
    cyc(1);
    chk("hold_busy", BUSY, 1);
    PIPELINE_READY = 1'b1;
    #1 chk("hold_pulse", INT_OUT, 7'h10);
    cyc(1);
    PIPELINE_READY = 1'b0;
    #1 chk("hold_nopulse", INT_OUT, 7'h00);
    S_INT = 1'b1;
    cyc(1);
    S_INT = 1'b0;
    chk("hold_ack", PENDING, 7'h00);
    // single source, pulse and ack
    IRQ_IN = 7'h01;
    cyc(2);
    chk("t1_sync", PENDING, 7'h00);
    cyc(1);
    chk("t1_pend", PENDING, 7'h01);
    chk("t1_idle", BUSY, 0);
    IRQ_IN = '0;
    cyc(1);
    chk("t1_busy", BUSY, 1);
    chk("t1_wait_pr", INT_OUT, 7'h00);
    PIPELINE_READY = 1'b1;
    #1 chk("t1_pulse", INT_OUT, 7'h01);
    cyc(1);
    PIPELINE_READY = 1'b0;
    #1 chk("t1_after", INT_OUT, 7'h00);
    chk("t1_wack", BUSY, 1);
    S_INT = 1'b1;
    cyc(1);
    S_INT = 1'b0;
    chk("t1_clr", PENDING, 7'h00);
    chk("t1_done", BUSY, 0);
    // two simultaneous sources, lowest first
    IRQ_IN = 7'h06;
    cyc(3);
    chk("t2_pend", PENDING, 7'h06);
    IRQ_IN = '0;
    cyc(1);
    PIPELINE_READY = 1'b1;
    #1 chk("t2_first", INT_OUT, 7'h02);
    cyc(1);
    PIPELINE_READY = 1'b0;
    S_INT = 1'b1;
    cyc(1);
    S_INT = 1'b0;
    chk("t2_left", PENDING, 7'h04);
    cyc(1);
    PIPELINE_READY = 1'b1;
    #1 chk("t2_second", INT_OUT, 7'h04);
    cyc(1);
    PIPELINE_READY = 1'b0;
    S_INT = 1'b1;
    cyc(1);
    S_INT = 1'b0;
    chk("t2_clr", PENDING, 7'h00);
    // masked source, then unmask
    MASK_WE = 1'b1;
    MASK_IN = 7'h00;
    cyc(1);
    MASK_WE = 1'b0;
    IRQ_IN = 7'h01;
    cyc(3);
    chk("t3_pend", PENDING, 7'h01);
    IRQ_IN = '0;
    PIPELINE_READY = 1'b1;
    cyc(2);
    chk("t3_masked", INT_OUT, 7'h00);
    chk("t3_idle", BUSY, 0);
    PIPELINE_READY = 1'b0;
    MASK_WE = 1'b1;
    MASK_IN = 7'h01;
    cyc(1);
    MASK_WE = 1'b0;
    cyc(1);
    chk("t3_busy", BUSY, 1);
    PIPELINE_READY = 1'b1;
    #1 chk("t3_pulse", INT_OUT, 7'h01);
    cyc(1);
    PIPELINE_READY = 1'b0;
    // no S_INT: timeout after ACK_TIMEOUT cycles
    cyc(15);
    chk("t4_hold", BUSY, 1);
    cyc(1);
    chk("t4_timeout", BUSY, 0);
    chk("t4_kept", PENDING, 7'h01);
    cyc(1);
    PIPELINE_READY = 1'b1;
    #1 chk("t4_repulse", INT_OUT, 7'h01);
    cyc(1);
    PIPELINE_READY = 1'b0;
    S_INT = 1'b1;
    cyc(1);
    S_INT = 1'b0;
    chk("t4_clr", PENDING, 7'h00);
    MASK_WE = 1'b1;
    MASK_IN = 7'h7F;
    cyc(1);
    MASK_WE = 1'b0;
    // pending cleared while presenting aborts without pulse
    IRQ_IN = 7'h08;
    cyc(3);
    chk("ab_pend", PENDING, 7'h08);
    IRQ_IN = '0;
    cyc(1);
    chk("ab_busy", BUSY, 1);
    CLR_WE = 1'b1;
    CLR_IN = 7'h08;
    cyc(1);
    CLR_WE = 1'b0;
    chk("ab_clr", PENDING, 7'h00);
    PIPELINE_READY = 1'b1;
    #1 chk("ab_nopulse", INT_OUT, 7'h00);
    cyc(1);
    PIPELINE_READY = 1'b0;
    chk("ab_idle", BUSY, 0);
    // set wins over coincident clear
    IRQ_IN = 7'h01;
    cyc(2);
    CLR_WE = 1'b1;
    CLR_IN = 7'h01;
    cyc(1);
    chk("t5_setwins", PENDING, 7'h01);
    IRQ_IN = '0;
    cyc(1);
    CLR_WE = 1'b0;
    chk("t5_clr", PENDING, 7'h00);
    cyc(1);
    chk("t5_idle", BUSY, 0);
`ifdef INT_TIMER_EN
    MASK_WE = 1'b1;
    MASK_IN = 7'h00;
    cyc(1);
    MASK_WE = 1'b0;
    TIMER_WE = 1'b1;
    TIMER_LOAD = 32'd5;
    cyc(1);
    TIMER_WE = 1'b0;
    cyc(4);
    chk("tm_early", PENDING, 7'h00);
    cyc(1);
    chk("tm_exp1", PENDING, 7'h40);
    CLR_WE = 1'b1;
    CLR_IN = 7'h40;
    cyc(1);
    CLR_WE = 1'b0;
    chk("tm_cleared", PENDING, 7'h00);
    cyc(3);
    chk("tm_gap", PENDING, 7'h00);
    cyc(1);
    chk("tm_exp2", PENDING, 7'h40);
    TIMER_WE = 1'b1;
    TIMER_LOAD = 32'd0;
    CLR_WE = 1'b1;
    cyc(1);
    TIMER_WE = 1'b0;
    CLR_WE = 1'b0;
    cyc(12);
    chk("tm_stopped", PENDING, 7'h00);
    MASK_WE = 1'b1;
    MASK_IN = 7'h7F;
    cyc(1);
    MASK_WE = 1'b0;
`endif
    // reset mid-presentation aborts with no pulse
    IRQ_IN = 7'h02;
    cyc(3);
    IRQ_IN = '0;
    cyc(1);
    chk("rm_busy", BUSY, 1);
    PIPELINE_READY = 1'b1;
    RESET = 1'b1;
    #1;
    chk("rm_int", INT_OUT, 7'h00);
    chk("rm_idle", BUSY, 0);
    chk("rm_pend", PENDING, 7'h00);
    cyc(1);
    RESET = 1'b0;
    PIPELINE_READY = 1'b0;
    cyc(2);
    chk("rm_after", PENDING, 7'h00);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
